iq_index_recycler: RTL and testbench
====================================

IQ_INDEX_RECYCLER -- requirements
Module: iq_index_recycler

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 16; issue queue entries managed; power of 2.
REQ-002 SHALL have parameter ALLOC_WIDTH, default 2; dispatch allocation lanes.
REQ-003 SHALL have parameter RELEASE_WIDTH, default 2; issue-time release lanes.
REQ-004 SHALL have parameter RETURN_WIDTH, default 2; flush-return lanes (receiver end of the issue queue's multi-cycle index return port).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port allocReq  input  ALLOC_WIDTH  per-lane allocation request; lanes contiguous from lane 0.
REQ-008 SHALL have port allocGrant  output  1  all requested lanes granted this cycle.
REQ-009 SHALL have port allocPtr  output  ALLOC_WIDTH x log2(ENTRY_NUM)  index per lane.
REQ-010 SHALL have port releaseValid / releasePtr  input  RELEASE_WIDTH / RELEASE_WIDTH x log2(ENTRY_NUM)  indices freed at issue.
REQ-011 SHALL have port returnValid / returnPtr  input  RETURN_WIDTH / RETURN_WIDTH x log2(ENTRY_NUM)  indices freed by selective flush.
REQ-012 SHALL have port freeCount  output  log2(ENTRY_NUM)+1  registered free-entry count.
REQ-013 SHALL have port initBusy  output  1  high while initialisation is in progress.
REQ-014 SHALL have port overflowErr  output  1  sticky; more frees than capacity.

Function
REQ-015 SHALL hold free indices in a circular FIFO of ENTRY_NUM slots with head, tail and count registers; head and tail wrap modulo ENTRY_NUM.
REQ-016 SHALL implement a two-state FSM, INIT and RUN; reset enters INIT.
REQ-017 In INIT, SHALL write indices k..k+RELEASE_WIDTH+RETURN_WIDTH-1 into slots k.. each cycle, starting at k=0.
REQ-018 SHALL take ceil(ENTRY_NUM/(RELEASE_WIDTH+RETURN_WIDTH)) INIT cycles (4 at defaults), then enter RUN with count=ENTRY_NUM, head=0 and tail=0.
REQ-019 During INIT, SHALL force allocGrant=0 and ignore release, return and allocReq.
REQ-020 SHALL drive allocPtr[i] = slot[head+i] combinationally, irrespective of the request.
REQ-021 In RUN, SHALL assert allocGrant when popcount(allocReq) <= count; all-or-nothing, no partial grant.
REQ-022 When granted, head SHALL advance by popcount(allocReq) and count SHALL decrease by the same amount at the next edge.
REQ-023 SHALL pack valid frees contiguously at tail in the order: release lanes ascending, then return lanes ascending; tail SHALL advance by the number of valid frees.
REQ-024 Indices freed in cycle t SHALL NOT be allocatable before cycle t+1; count SHALL use the registered value only.
REQ-025 With simultaneous grant and frees, next count SHALL equal count - granted + freed.
REQ-026 SHALL set overflowErr, drop all frees that cycle and leave tail unchanged when count - granted + freed > ENTRY_NUM; overflowErr SHALL clear only on reset.
REQ-027 freeCount SHALL equal the count register; an empty list (count=0) with any request SHALL yield allocGrant=0.
REQ-028 SHALL perform no duplicate-index detection; that is a verification assertion only.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately set FSM=INIT, head=0, tail=0, count=0, init counter=0 and overflowErr=0; slot contents are don't-care.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL discard all state and restart initialisation from k=0 after deassertion.
REQ-031 Reset outputs SHALL be allocGrant=0, freeCount=0, initBusy=1 and overflowErr=0.

Verification
REQ-032 Release reset, idle for 4 cycles -> initBusy falls in cycle 5; freeCount=16; allocPtr={1,0}.
REQ-033 allocReq=2'b11 each cycle for 8 cycles -> indices 0..15 handed out in order; freeCount=0; ninth request -> allocGrant=0.
REQ-034 With count=1 and allocReq=2'b11 -> allocGrant=0; count stays 1; head is unchanged.
REQ-035 With count=14, granted allocReq=2'b11 plus releasePtr={9,5} valid in the same cycle -> next count=14; slots tail and tail+1 hold 5 and 9; 5 is not allocPtr in that cycle.
REQ-036 With count=15, release two indices -> overflowErr=1; tail unchanged; error persists until rst_n pulse.
REQ-037 Pulse rst_n low during the 2nd INIT cycle -> initBusy stays high; full 4-cycle initialisation repeats; final freeCount=16.

Source files
------------

// File: rtl/iq_index_recycler.sv
// Free-index list for an issue queue: a circular FIFO of entry indices that is
// self-initialised after reset, popped by dispatch and refilled by issue/flush.
module iq_index_recycler #(
    parameter int ENTRY_NUM     = 16,
    parameter int ALLOC_WIDTH   = 2,
    parameter int RELEASE_WIDTH = 2,
    parameter int RETURN_WIDTH  = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [ALLOC_WIDTH-1:0]                        allocReq,
    output logic                                          allocGrant,
    output logic [ALLOC_WIDTH*$clog2(ENTRY_NUM)-1:0]      allocPtr,
    input  logic [RELEASE_WIDTH-1:0]                      releaseValid,
    input  logic [RELEASE_WIDTH*$clog2(ENTRY_NUM)-1:0]    releasePtr,
    input  logic [RETURN_WIDTH-1:0]                       returnValid,
    input  logic [RETURN_WIDTH*$clog2(ENTRY_NUM)-1:0]     returnPtr,
    output logic [$clog2(ENTRY_NUM):0]                    freeCount,
    output logic                                          initBusy,
    output logic                                          overflowErr
);

    localparam int IDX_W  = $clog2(ENTRY_NUM);
    localparam int CNT_W  = IDX_W + 1;
    localparam int FREE_W = RELEASE_WIDTH + RETURN_WIDTH;
    localparam int SUM_W  = $clog2(ENTRY_NUM + FREE_W + ALLOC_WIDTH + 1) + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SUM_W-1:0] init_k_q, init_k_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] slot_q [ENTRY_NUM];

    logic [SUM_W-1:0] req_cnt, free_cnt, granted, next_sum;
    logic [FREE_W-1:0] free_vld;
    logic [IDX_W-1:0] free_ptr [FREE_W];
    logic [IDX_W-1:0] free_idx [FREE_W];
    logic [FREE_W-1:0] init_we;
    logic [IDX_W-1:0] init_idx [FREE_W];
    logic             run, grant, overflow, do_free;

    // Frees are packed release lanes first, then return lanes, each ascending.
    always_comb begin
        free_vld = {returnValid, releaseValid};
        for (int l = 0; l < FREE_W; l++) begin
            free_ptr[l] = '0;
        end
        for (int l = 0; l < RELEASE_WIDTH; l++) begin
            free_ptr[l] = releasePtr[l*IDX_W +: IDX_W];
        end
        for (int l = 0; l < RETURN_WIDTH; l++) begin
            free_ptr[RELEASE_WIDTH+l] = returnPtr[l*IDX_W +: IDX_W];
        end
        free_cnt = '0;
        for (int l = 0; l < FREE_W; l++) begin
            free_idx[l] = tail_q + free_cnt[IDX_W-1:0];
            free_cnt    = free_cnt + SUM_W'(free_vld[l]);
        end
    end

    always_comb begin
        for (int j = 0; j < FREE_W; j++) begin
            init_idx[j] = init_k_q[IDX_W-1:0] + IDX_W'(j);
            init_we[j]  = (init_k_q + SUM_W'(j)) < SUM_W'(ENTRY_NUM);
        end
    end

    always_comb begin
        req_cnt = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            req_cnt = req_cnt + SUM_W'(allocReq[i]);
        end
    end

    // Grant looks only at the registered count, so same-cycle frees never feed allocation.
    assign run      = (state_q == ST_RUN);
    assign grant    = run && (req_cnt <= SUM_W'(count_q));
    assign granted  = grant ? req_cnt : '0;
    assign next_sum = SUM_W'(count_q) - granted + free_cnt;
    assign overflow = run && (next_sum > SUM_W'(ENTRY_NUM));
    assign do_free  = run && !overflow;

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        init_k_d = init_k_q;
        err_d    = err_q;
        case (state_q)
            ST_INIT: begin
                init_k_d = init_k_q + SUM_W'(FREE_W);
                if ((init_k_q + SUM_W'(FREE_W)) >= SUM_W'(ENTRY_NUM)) begin
                    state_d  = ST_RUN;
                    count_d  = CNT_W'(ENTRY_NUM);
                    head_d   = '0;
                    tail_d   = '0;
                    init_k_d = '0;
                end
            end
            ST_RUN: begin
                if (grant) begin
                    head_d = head_q + req_cnt[IDX_W-1:0];
                end
                if (overflow) begin
                    err_d   = 1'b1;
                    count_d = count_q - granted[CNT_W-1:0];
                end else begin
                    tail_d  = tail_q + free_cnt[IDX_W-1:0];
                    count_d = next_sum[CNT_W-1:0];
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            init_k_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            init_k_q <= init_k_d;
            err_q    <= err_d;
        end
    end

    // Slot storage carries no reset; INIT rewrites every slot before use.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            for (int j = 0; j < FREE_W; j++) begin
                if (init_we[j]) slot_q[init_idx[j]] <= init_idx[j];
            end
        end else if (do_free) begin
            for (int l = 0; l < FREE_W; l++) begin
                if (free_vld[l]) slot_q[free_idx[l]] <= free_ptr[l];
            end
        end
    end

    always_comb begin
        allocPtr = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            allocPtr[i*IDX_W +: IDX_W] = slot_q[head_q + IDX_W'(i)];
        end
    end

    assign allocGrant  = grant;
    assign freeCount   = count_q;
    assign initBusy    = (state_q == ST_INIT);
    assign overflowErr = err_q;

endmodule

// File: tb/tb_iq_index_recycler.sv
// Bench for iq_index_recycler: directed vector table, randomized traffic against
// a queue-based free-list model, and a reset-during-initialisation sequence.
module tb_iq_index_recycler;

    localparam int N  = 16;
    localparam int IW = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] allocReq;
    logic       allocGrant;
    logic [7:0] allocPtr;
    logic [1:0] releaseValid;
    logic [7:0] releasePtr;
    logic [1:0] returnValid;
    logic [7:0] returnPtr;
    logic [4:0] freeCount;
    logic       initBusy;
    logic       overflowErr;

    int checks;
    int failures;

    // Reference model: the free list as an ordered queue of indices.
    int fifo[$];
    int outst[$];
    int init_left;
    bit m_err;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] relv;
        logic [3:0] rel1;
        logic [3:0] rel0;
        logic [1:0] retv;
        logic [3:0] ret1;
        logic [3:0] ret0;
        logic       e_busy;
        logic       e_grant;
        logic       e_err;
        logic [4:0] e_cnt;
        logic [1:0] e_mask;
        logic [3:0] e_p1;
        logic [3:0] e_p0;
    } vec_t;

    vec_t tbl[$];

    iq_index_recycler #(
        .ENTRY_NUM(N), .ALLOC_WIDTH(2), .RELEASE_WIDTH(2), .RETURN_WIDTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .allocReq(allocReq), .allocGrant(allocGrant), .allocPtr(allocPtr),
        .releaseValid(releaseValid), .releasePtr(releasePtr),
        .returnValid(returnValid), .returnPtr(returnPtr),
        .freeCount(freeCount), .initBusy(initBusy), .overflowErr(overflowErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        outst.delete();
        init_left = 4;
        m_err = 1'b0;
    endtask

    // Compare DUT against the model for the current inputs, then advance the model.
    task automatic model_check();
        int n, sz, g;
        int frees[$];
        if (init_left > 0) begin
            chk("m_init_busy", initBusy, 1);
            chk("m_init_grant", allocGrant, 0);
            chk("m_init_cnt", freeCount, 0);
            chk("m_init_err", overflowErr, 0);
            init_left--;
            if (init_left == 0) begin
                fifo.delete();
                for (int k = 0; k < N; k++) fifo.push_back(k);
            end
        end else begin
            n  = int'(allocReq[0]) + int'(allocReq[1]);
            sz = fifo.size();
            chk("m_busy", initBusy, 0);
            chk("m_grant", allocGrant, (n <= sz) ? 1 : 0);
            chk("m_cnt", freeCount, sz);
            chk("m_err", overflowErr, m_err);
            for (int i = 0; i < 2; i++) begin
                if (i < sz) chk($sformatf("m_ptr%0d", i), allocPtr[i*IW +: IW], fifo[i]);
            end
            for (int i = 0; i < 2; i++) if (releaseValid[i]) frees.push_back(int'(releasePtr[i*IW +: IW]));
            for (int i = 0; i < 2; i++) if (returnValid[i]) frees.push_back(int'(returnPtr[i*IW +: IW]));
            g = (n <= sz) ? n : 0;
            for (int k = 0; k < g; k++) outst.push_back(fifo.pop_front());
            if (sz - g + frees.size() > N) m_err = 1'b1;
            else foreach (frees[k]) fifo.push_back(frees[k]);
        end
    endtask

    task automatic idle_inputs();
        allocReq     = '0;
        releaseValid = '0;
        releasePtr   = '0;
        returnValid  = '0;
        returnPtr    = '0;
    endtask

    // Entered just after a rising edge; leaves reset released before the next falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        chk("rst_grant", allocGrant, 0);
        chk("rst_cnt", freeCount, 0);
        chk("rst_busy", initBusy, 1);
        chk("rst_err", overflowErr, 0);
        #10;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_row(input int r, input vec_t v);
        if (v.rst) do_reset();
        allocReq     = v.req;
        releaseValid = v.relv;
        releasePtr   = {v.rel1, v.rel0};
        returnValid  = v.retv;
        returnPtr    = {v.ret1, v.ret0};
        @(negedge clk);
        chk($sformatf("row%0d_busy", r), initBusy, v.e_busy);
        chk($sformatf("row%0d_grant", r), allocGrant, v.e_grant);
        chk($sformatf("row%0d_err", r), overflowErr, v.e_err);
        chk($sformatf("row%0d_cnt", r), freeCount, v.e_cnt);
        if (v.e_mask[0]) chk($sformatf("row%0d_ptr0", r), allocPtr[3:0], v.e_p0);
        if (v.e_mask[1]) chk($sformatf("row%0d_ptr1", r), allocPtr[7:4], v.e_p1);
        model_check();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic [1:0] relv,
                                input logic [3:0] rel1, input logic [3:0] rel0,
                                input logic [1:0] retv, input logic [3:0] ret1, input logic [3:0] ret0,
                                input logic eb, input logic eg, input logic ee, input logic [4:0] ec,
                                input logic [1:0] em, input logic [3:0] ep1, input logic [3:0] ep0);
        vec_t v;
        v.rst = rst; v.req = req; v.relv = relv; v.rel1 = rel1; v.rel0 = rel0;
        v.retv = retv; v.ret1 = ret1; v.ret0 = ret0;
        v.e_busy = eb; v.e_grant = eg; v.e_err = ee; v.e_cnt = ec;
        v.e_mask = em; v.e_p1 = ep1; v.e_p0 = ep0;
        return v;
    endfunction

    task automatic build_table();
        // Initialisation ignores requests and frees, then exposes 16 free entries.
        tbl.push_back(mk(1, 2'b11, 2'b11, 7, 3, 2'b11, 12, 13, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 2'b11, 2'b11, 7, 3, 2'b11, 12, 13, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16, 2'b11, 1, 0));
        // Drain all sixteen in order, then refuse on empty.
        for (int m = 0; m < 8; m++)
            tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'(16 - 2*m), 2'b11, 4'(2*m + 1), 4'(2*m)));
        tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // One entry back; a two-lane request must not be partially granted.
        tbl.push_back(mk(0, 2'b00, 2'b01, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 4));
        tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 4));
        tbl.push_back(mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b01, 0, 4));
        tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Grant plus two frees in the same cycle; frees land at the tail as 5 then 9.
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16, 2'b11, 1, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 9, 5, 0, 0, 0, 0, 1, 0, 14, 2'b11, 3, 2));
        for (int m = 0; m < 6; m++)
            tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'(14 - 2*m), 2'b11, 4'(5 + 2*m), 4'(4 + 2*m)));
        tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 2'b11, 9, 5));
        // Overflow: two frees at count 15 are dropped and the error sticks.
        tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16, 2'b11, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b11, 1, 0, 0, 0, 0, 0, 1, 0, 15, 2'b11, 2, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 15, 2'b11, 2, 1));
        tbl.push_back(mk(0, 2'b01, 0, 0, 0, 2'b01, 0, 0, 0, 1, 1, 15, 2'b11, 2, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 15, 2'b11, 3, 2));
    endtask

    task automatic random_phase();
        int r, idx, p;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            r = $urandom_range(0, 2);
            allocReq     = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
            releaseValid = '0;
            returnValid  = '0;
            releasePtr   = 8'($urandom);
            returnPtr    = 8'($urandom);
            for (int l = 0; l < 4; l++) begin
                if (outst.size() > 0 && $urandom_range(0, 2) == 0) begin
                    idx = $urandom_range(0, outst.size() - 1);
                    p   = outst[idx];
                    outst.delete(idx);
                    if (l < 2) begin
                        releaseValid[l]         = 1'b1;
                        releasePtr[l*IW +: IW]  = 4'(p);
                    end else begin
                        returnValid[l-2]           = 1'b1;
                        returnPtr[(l-2)*IW +: IW]  = 4'(p);
                    end
                end
            end
            step();
        end
    endtask

    task automatic reset_mid_init();
        int  busy_cyc;
        bit  fell;
        do_reset();
        idle_inputs();
        step();
        #1;
        rst_n = 1'b0;
        #2;
        chk("midrst_busy", initBusy, 1);
        chk("midrst_cnt", freeCount, 0);
        chk("midrst_grant", allocGrant, 0);
        rst_n = 1'b1;
        model_reset();
        busy_cyc = 0;
        fell = 1'b0;
        for (int c = 0; c < 12 && !fell; c++) begin
            @(negedge clk);
            if (!initBusy) fell = 1'b1;
            else busy_cyc++;
            if (!fell) begin
                @(posedge clk);
                #1;
            end
        end
        chk("midrst_fell", fell, 1);
        chk("midrst_init_cycles", busy_cyc, 4);
        chk("midrst_final_cnt", freeCount, 16);
        chk("midrst_ptr", allocPtr, 8'h10);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();
        model_reset();
        build_table();
        @(posedge clk);
        #1;
        foreach (tbl[r]) apply_row(r, tbl[r]);
        random_phase();
        reset_mid_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
